// File: rtl/lcd_pattern_pkg.sv
// Shared definitions for the LCD test-pattern generator: modes, RGB565 colours
// and the eight-entry bar palette.
package lcd_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_VBAR  = 2'd0,
        MODE_HBAR  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_RAMP  = 2'd3
    } mode_e;

    localparam logic [15:0] COLOR_WHITE   = 16'hFFFF;
    localparam logic [15:0] COLOR_BLACK   = 16'h0000;
    localparam logic [15:0] COLOR_RED     = 16'hF800;
    localparam logic [15:0] COLOR_GREEN   = 16'h07E0;
    localparam logic [15:0] COLOR_BLUE    = 16'h001F;
    localparam logic [15:0] COLOR_YELLOW  = 16'hFFE0;
    localparam logic [15:0] COLOR_CYAN    = 16'h07FF;
    localparam logic [15:0] COLOR_MAGENTA = 16'hF81F;

    function automatic logic [15:0] palette_colour(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = COLOR_WHITE;
            3'd1:    c = COLOR_BLACK;
            3'd2:    c = COLOR_RED;
            3'd3:    c = COLOR_GREEN;
            3'd4:    c = COLOR_BLUE;
            3'd5:    c = COLOR_YELLOW;
            3'd6:    c = COLOR_CYAN;
            3'd7:    c = COLOR_MAGENTA;
            default: c = COLOR_BLACK;
        endcase
        return c;
    endfunction

    // Six-bit grey level spread over RGB565: red and blue drop the LSB.
    function automatic logic [15:0] ramp_colour(input logic [5:0] lvl);
        return {lvl[5:1], lvl, lvl[5:1]};
    endfunction

endpackage

// File: rtl/lcd_pattern_if.sv
// Pixel request/response bundle between a display timing master and the
// pattern generator.
interface lcd_pattern_if;
    logic        pixel_en;
    logic [10:0] pixel_x;
    logic [10:0] pixel_y;
    logic [10:0] h_res;
    logic [10:0] v_res;
    logic [1:0]  mode_sel;
    logic [15:0] pixel_data;
    logic        pixel_valid;
    logic [1:0]  mode_cur;

    modport master (
        output pixel_en, pixel_x, pixel_y, h_res, v_res, mode_sel,
        input  pixel_data, pixel_valid, mode_cur
    );

    modport slave (
        input  pixel_en, pixel_x, pixel_y, h_res, v_res, mode_sel,
        output pixel_data, pixel_valid, mode_cur
    );
endinterface

// File: rtl/lcd_frac_step.sv
// Divider-free floor(n*STEP/limit) stepper: index/acc describe the current
// request (combinational), registers keep the value of the last request.
module lcd_frac_step #(
    parameter int STEP      = 1,
    parameter int WIDTH     = 11,
    parameter int IDX_W     = 4,
    parameter int MAX_INDEX = 1
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             restart,
    input  logic             advance,
    input  logic [WIDTH-1:0] limit,
    output logic [IDX_W-1:0] index,
    output logic [WIDTH-1:0] acc
);

    logic [IDX_W-1:0] idx_r, idx_s, step_idx_s;
    logic [WIDTH-1:0] acc_r, acc_s, step_acc_s;
    logic [WIDTH:0]   sum_s;

    // Next stepper value and the value presented for the current request.
    always_comb begin
        sum_s      = {1'b0, acc_r} + (WIDTH+1)'(STEP);
        step_idx_s = idx_r;
        step_acc_s = sum_s[WIDTH-1:0];
        if (sum_s >= {1'b0, limit}) begin
            step_acc_s = WIDTH'(sum_s - {1'b0, limit});
            if (idx_r != IDX_W'(MAX_INDEX)) begin
                step_idx_s = idx_r + IDX_W'(1);
            end else begin
                step_idx_s = idx_r;
            end
        end else begin
            step_acc_s = sum_s[WIDTH-1:0];
        end

        if (restart) begin
            idx_s = '0;
            acc_s = '0;
        end else if (advance) begin
            idx_s = step_idx_s;
            acc_s = step_acc_s;
        end else begin
            idx_s = idx_r;
            acc_s = acc_r;
        end
    end

    // Remember the value used by the latest restart/advance request.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            idx_r <= '0;
            acc_r <= '0;
        end else if (restart || advance) begin
            idx_r <= idx_s;
            acc_r <= acc_s;
        end
    end

    assign index = idx_s;
    assign acc   = acc_s;

endmodule

// File: rtl/lcd_pattern_gen.sv
// LCD test-pattern generator (bars, checkerboard, grey ramp), one-cycle latency.
// Define LCD_PATTERN_AUTO_CYCLE_EN to step the mode every AUTO_FRAMES frames.
module lcd_pattern_gen
    import lcd_pattern_pkg::*;
#(
    parameter int NUM_BARS    = 5,
    parameter int CHECK_LOG2  = 4,
    parameter int AUTO_FRAMES = 60
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    lcd_pattern_if.slave  bus
);

    logic        line_start_s, frame_start_s, col_adv_s, row_adv_s, check_bit_s;
    logic [3:0]  col_idx_s, row_idx_s;
    logic [5:0]  ramp_lvl_s;
    logic [10:0] col_acc_unused_s, row_acc_unused_s, ramp_acc_unused_s;
    logic [15:0] colour_s;
    mode_e       mode_eff_s;

    logic [15:0] pixel_data_r;
    logic        pixel_valid_r;
    mode_e       mode_cur_r;

    assign line_start_s  = bus.pixel_en && (bus.pixel_x == 11'd0);
    assign frame_start_s = line_start_s && (bus.pixel_y == 11'd0);
    assign col_adv_s     = bus.pixel_en && (bus.pixel_x != 11'd0);
    assign row_adv_s     = line_start_s && (bus.pixel_y != 11'd0);
    assign check_bit_s   = bus.pixel_x[CHECK_LOG2] ^ bus.pixel_y[CHECK_LOG2];

    lcd_frac_step #(.STEP(NUM_BARS), .WIDTH(11), .IDX_W(4), .MAX_INDEX(NUM_BARS-1)) u_col_step (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .restart(line_start_s), .advance(col_adv_s),
        .limit(bus.h_res), .index(col_idx_s), .acc(col_acc_unused_s)
    );

    lcd_frac_step #(.STEP(NUM_BARS), .WIDTH(11), .IDX_W(4), .MAX_INDEX(NUM_BARS-1)) u_row_step (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .restart(frame_start_s), .advance(row_adv_s),
        .limit(bus.v_res), .index(row_idx_s), .acc(row_acc_unused_s)
    );

    lcd_frac_step #(.STEP(64), .WIDTH(11), .IDX_W(6), .MAX_INDEX(63)) u_ramp_step (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .restart(line_start_s), .advance(col_adv_s),
        .limit(bus.h_res), .index(ramp_lvl_s), .acc(ramp_acc_unused_s)
    );

`ifdef LCD_PATTERN_AUTO_CYCLE_EN
    logic [9:0] frame_cnt_r;
    logic       started_r;

    // The very first frame after reset opens mode 0; later frame starts count it.
    always_comb begin
        if (frame_start_s && started_r && (frame_cnt_r == 10'(AUTO_FRAMES - 1))) begin
            mode_eff_s = mode_e'(mode_cur_r + 2'd1);
        end else begin
            mode_eff_s = mode_cur_r;
        end
    end

    // Frame counter for the auto-cycle.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            frame_cnt_r <= 10'd0;
            started_r   <= 1'b0;
        end else if (frame_start_s) begin
            started_r <= 1'b1;
            if (!started_r) begin
                frame_cnt_r <= 10'd0;
            end else if (frame_cnt_r == 10'(AUTO_FRAMES - 1)) begin
                frame_cnt_r <= 10'd0;
            end else begin
                frame_cnt_r <= frame_cnt_r + 10'd1;
            end
        end
    end
`else
    // mode_sel takes effect only on the frame-start pixel.
    always_comb begin
        if (frame_start_s) begin
            mode_eff_s = mode_e'(bus.mode_sel);
        end else begin
            mode_eff_s = mode_cur_r;
        end
    end
`endif

    // Colour for the pixel being requested this cycle.
    always_comb begin
        case (mode_eff_s)
            MODE_VBAR:  colour_s = palette_colour(col_idx_s[2:0]);
            MODE_HBAR:  colour_s = palette_colour(row_idx_s[2:0]);
            MODE_CHECK: colour_s = check_bit_s ? COLOR_BLACK : COLOR_WHITE;
            MODE_RAMP:  colour_s = ramp_colour(ramp_lvl_s);
            default:    colour_s = COLOR_BLACK;
        endcase
    end

    // Output registers; data holds between requests.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            pixel_data_r  <= 16'h0000;
            pixel_valid_r <= 1'b0;
            mode_cur_r    <= MODE_VBAR;
        end else begin
            pixel_valid_r <= bus.pixel_en;
            if (bus.pixel_en) begin
                pixel_data_r <= colour_s;
            end
            if (frame_start_s) begin
                mode_cur_r <= mode_eff_s;
            end
        end
    end

    assign bus.pixel_data  = pixel_data_r;
    assign bus.pixel_valid = pixel_valid_r;
    assign bus.mode_cur    = mode_cur_r;

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// Directed self-checking bench for lcd_pattern_gen (default build, or the
// auto-cycle build when LCD_PATTERN_AUTO_CYCLE_EN is defined).
module tb_lcd_pattern_gen;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    int   checks  = 0;
    int   errors  = 0;

    lcd_pattern_if bus ();

    lcd_pattern_gen #(.NUM_BARS(5), .CHECK_LOG2(4), .AUTO_FRAMES(2)) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .bus(bus)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] pal(input int i);
        logic [15:0] c;
        case (i % 8)
            0:       c = 16'hFFFF;
            1:       c = 16'h0000;
            2:       c = 16'hF800;
            3:       c = 16'h07E0;
            4:       c = 16'h001F;
            5:       c = 16'hFFE0;
            6:       c = 16'h07FF;
            default: c = 16'hF81F;
        endcase
        return c;
    endfunction

    function automatic logic [15:0] ramp(input int x, input int h);
        logic [5:0] lv;
        lv = 6'(x * 64 / h);
        return {lv[5:1], lv, lv[5:1]};
    endfunction

    // One request, then a gap; on return the response is on the outputs.
    task automatic pix(input int x, input int y);
        @(negedge sys_clk);
        bus.pixel_en = 1'b1;
        bus.pixel_x  = 11'(x);
        bus.pixel_y  = 11'(y);
        @(negedge sys_clk);
        bus.pixel_en = 1'b0;
        chk("valid", {15'd0, bus.pixel_valid}, 16'd1);
    endtask

    initial begin
        bus.pixel_en = 1'b0;
        bus.pixel_x  = 11'd0;
        bus.pixel_y  = 11'd0;
        bus.h_res    = 11'd480;
        bus.v_res    = 11'd272;
        bus.mode_sel = 2'd0;
        repeat (3) @(negedge sys_clk);
        chk("rst_data", bus.pixel_data, 16'h0000);
        chk("rst_valid", {15'd0, bus.pixel_valid}, 16'd0);
        chk("rst_mode", {14'd0, bus.mode_cur}, 16'd0);
        sys_rst = 1'b0;
        @(negedge sys_clk);

`ifdef LCD_PATTERN_AUTO_CYCLE_EN
        begin
            int exp_mode [6] = '{0, 0, 1, 1, 2, 2};
            bus.mode_sel = 2'd3;
            for (int f = 0; f < 6; f++) begin
                pix(0, 0);
                chk($sformatf("auto_mode_f%0d", f), {14'd0, bus.mode_cur}, 16'(exp_mode[f]));
                pix(1, 0);
            end
        end
`else
        // Vertical bars across a 480-wide line.
        for (int x = 0; x < 480; x++) begin
            pix(x, 0);
            chk($sformatf("vbar_x%0d", x), bus.pixel_data, pal(x * 5 / 480));
        end
        chk("vbar_mode", {14'd0, bus.mode_cur}, 16'd0);
        @(negedge sys_clk);
        chk("idle_valid", {15'd0, bus.pixel_valid}, 16'd0);
        chk("idle_hold", bus.pixel_data, 16'h001F);

        // mode_sel change mid-frame waits for the next frame start.
        for (int x = 0; x < 100; x++) pix(x, 0);
        bus.mode_sel = 2'd2;
        for (int x = 100; x <= 150; x++) pix(x, 0);
        chk("midframe_mode", {14'd0, bus.mode_cur}, 16'd0);
        chk("midframe_data", bus.pixel_data, 16'h0000);
        pix(0, 0);
        chk("newframe_mode", {14'd0, bus.mode_cur}, 16'd2);
        chk("check_0_0", bus.pixel_data, 16'hFFFF);
        pix(15, 0);
        chk("check_15_0", bus.pixel_data, 16'hFFFF);
        pix(16, 0);
        chk("check_16_0", bus.pixel_data, 16'h0000);
        pix(16, 16);
        chk("check_16_16", bus.pixel_data, 16'hFFFF);
        pix(40, 20);
        chk("check_40_20", bus.pixel_data, 16'h0000);

        // Grey ramp.
        bus.mode_sel = 2'd3;
        for (int x = 0; x < 480; x++) begin
            pix(x, 0);
            chk($sformatf("ramp_x%0d", x), bus.pixel_data, ramp(x, 480));
            if (x == 240) chk("ramp_mid", bus.pixel_data, 16'h8410);
        end
        chk("ramp_end", bus.pixel_data, 16'hFFFF);
        chk("ramp_mode", {14'd0, bus.mode_cur}, 16'd3);

        // Reset asserted mid-line.
        bus.mode_sel = 2'd0;
        for (int x = 0; x < 200; x++) pix(x, 0);
        @(negedge sys_clk);
        bus.pixel_en = 1'b1;
        bus.pixel_x  = 11'd200;
        bus.pixel_y  = 11'd0;
        @(posedge sys_clk);
        #2 sys_rst = 1'b1;
        @(negedge sys_clk);
        bus.pixel_en = 1'b0;
        chk("midrst_data", bus.pixel_data, 16'h0000);
        chk("midrst_valid", {15'd0, bus.pixel_valid}, 16'd0);
        chk("midrst_mode", {14'd0, bus.mode_cur}, 16'd0);
        @(negedge sys_clk);
        sys_rst = 1'b0;

        // Horizontal bars over a full 64x272 frame.
        bus.h_res    = 11'd64;
        bus.mode_sel = 2'd1;
        for (int y = 0; y < 272; y++) begin
            for (int x = 0; x < 64; x++) begin
                pix(x, y);
                chk($sformatf("hbar_%0d_%0d", x, y), bus.pixel_data, pal(y * 5 / 272));
            end
        end
        chk("hbar_mode", {14'd0, bus.mode_cur}, 16'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_pattern_gen.md
LCD_PATTERN_GEN -- requirements
Module: lcd_pattern_gen

Interface
REQ-001 Parameter NUM_BARS, default 5: bar count for bar modes; legal range 2..16.
REQ-002 Parameter CHECK_LOG2, default 4: checkerboard square edge is 2^CHECK_LOG2 pixels.
REQ-003 Parameter AUTO_FRAMES, default 60: frames per mode in auto-cycle; legal range 1..1023.
REQ-004 sys_clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 sys_rst  in  1  reset is asynchronous and active-high.
REQ-006 pixel_en  in  1  one pixel request per asserted cycle.
REQ-007 pixel_x  in  11  column of the requested pixel.
REQ-008 pixel_y  in  11  row of the requested pixel.
REQ-009 h_res  in  11  active width; must be at least 64 and at least NUM_BARS.
REQ-010 v_res  in  11  active height; must be at least NUM_BARS.
REQ-011 mode_sel  in  2  requested mode: 0 vertical bars, 1 horizontal bars, 2 checkerboard, 3 grey ramp.
REQ-012 pixel_data  out  16  RGB565 value (R[15:11], G[10:5], B[4:0]).
REQ-013 pixel_valid  out  1  pixel_data holds the answer to the pixel_en of the previous cycle.
REQ-014 mode_cur  out  2  mode currently in effect.

Function
REQ-015 Latency: exactly 1 cycle.
- pixel_valid is pixel_en delayed by one cycle.
- pixel_data changes only in the cycle after a pixel_en.
- With pixel_en low, pixel_data holds its value.
REQ-016 Frame start is pixel_en with pixel_x==0 and pixel_y==0.
- mode_sel is sampled only at frame start and applies from that pixel onward.
- Changes to mode_sel mid-frame are ignored until the next frame start.
REQ-017 Column bar index is floor(pixel_x*NUM_BARS/h_res), computed with no divider.
- Error-accumulator stepper: acc += NUM_BARS per pixel; when acc >= h_res, subtract h_res and increment the index.
- Stepper resyncs to index 0, acc 0 on pixel_en with pixel_x==0.
- Requires pixel_x to advance by 1 per pixel_en within a line; a non-sequential x other than 0 gives undefined colour but no lock-up.
REQ-018 Row bar index is floor(pixel_y*NUM_BARS/v_res), using the same stepper.
- Steps once per line, on pixel_en with pixel_x==0 and pixel_y!=0.
- Resyncs at frame start.
REQ-019 Bar palette, selected by index mod 8: WHITE, BLACK, RED, GREEN, BLUE, YELLOW, CYAN, MAGENTA.
REQ-020 Checkerboard: WHITE when (pixel_x>>CHECK_LOG2 XOR pixel_y>>CHECK_LOG2) bit 0 is 0, else BLACK.
REQ-021 Grey ramp level L is floor(pixel_x*64/h_res), 6 bits, from a third stepper with step 64.
- Output R=L[5:1], G=L, B=L[5:1].
REQ-022 Index registers saturate at NUM_BARS-1 (ramp at 63); no wrap-around within a line or frame.

Reset
REQ-023 While sys_rst is high:
- pixel_data=16'h0000, pixel_valid=0, mode_cur=0.
- All steppers and the frame counter clear.
REQ-024 Reset mid-frame: after release, output is undefined until the first pixel_en with pixel_x==0 (and the frame start, for the row stepper); it must not hang.

Configuration
REQ-025 Macro LCD_PATTERN_AUTO_CYCLE_EN controls auto-cycle.
- Defined: a frame counter counts frame starts. When it reaches AUTO_FRAMES-1, the next frame start sets mode_cur to (mode_cur+1) mod 4 and clears the counter. mode_sel is ignored.
- Undefined: no counter is built and mode_cur follows REQ-016.

Structure
REQ-026 Shared package lcd_pattern_pkg holds:
- RGB565 colour constants;
- the 8-entry palette;
- the mode enumeration (2-bit).
REQ-027 Sub-module lcd_frac_step is the reusable error-accumulator stepper (parameters STEP and width; inputs restart, advance, limit; outputs index, acc). It is instantiated three times: column bars, row bars, ramp.

Verification
REQ-028 h_res=480, NUM_BARS=5, mode 0, line swept from x=0 -> x=95 WHITE, x=96 BLACK, x=287 RED, x=288 GREEN, x=479 16'h001F.
REQ-029 v_res=272, mode 1, full frame -> rows 0..54 WHITE, row 55 BLACK, row 271 BLUE; every pixel within a row identical.
REQ-030 mode 2, CHECK_LOG2=4 -> (15,0) 16'hFFFF, (16,0) 16'h0000, (16,16) 16'hFFFF.
REQ-031 mode 3, h_res=480 -> x=0 16'h0000, x=479 16'hFFFF, x=240 level 32 = 16'h8410.
REQ-032 mode_sel 0->2 at x=100 mid-frame -> mode_cur stays 0 until the next frame start, then 2. Reset asserted at x=200 -> the cycle after assertion shows pixel_data 0, pixel_valid 0, mode_cur 0.
REQ-033 With LCD_PATTERN_AUTO_CYCLE_EN and AUTO_FRAMES=2, six frames run -> mode_cur sequence 0,0,1,1,2,2.
